// File: rtl/addsub_accum.sv
// addsub_accum: accumulates COUNT signed add/sub results into a frame sum
// and presents it, with a sticky signed-overflow flag, on a valid/ready port.
module addsub_accum #(
    parameter int unsigned N     = 4,
    parameter int unsigned COUNT = 4,
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N+1:0]     in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned IN_W  = N + 2;
    localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic [IN_W-1:0]    z_in;
    logic [ACC_W-1:0]   z_ext;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;
    logic               accept;

    // Sign-extend the sample and form the wrapped sum with its overflow bit
    always_comb begin
        z_in    = in_z;
        z_ext   = ACC_W'($signed(z_in));
        sum     = acc_q + z_ext;
        add_ovf = (acc_q[ACC_W-1] == z_ext[ACC_W-1]) &&
                  (sum[ACC_W-1] != acc_q[ACC_W-1]);
        accept  = in_valid && (state_q == ST_ACC);
    end

    // Next-state: clear wins over everything, then accept / output handshake
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            state_d     = ST_ACC;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            out_valid_d = 1'b0;
            out_sum_d   = '0;
            out_ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            out_sum_d   = sum;
                            out_ovf_d   = ovf_acc_q | add_ovf;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            ovf_acc_d   = 1'b0;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d     = sum;
                            cnt_d     = cnt_q + CNT_W'(1);
                            ovf_acc_d = ovf_acc_q | add_ovf;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_addsub_accum.sv
// Scoreboard bench for addsub_accum: an 8-bit and a 6-bit accumulator share
// the same stimulus; a reference model predicts every frame result.
module tb_addsub_accum;

    localparam int unsigned N     = 4;
    localparam int unsigned COUNT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_z = '0;
    logic       out_ready = 1'b0;

    logic       in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_sum8;
    logic       in_ready6, out_valid6, out_ovf6;
    logic [5:0] out_sum6;

    addsub_accum #(.N(N), .COUNT(COUNT), .ACC_W(8)) d8 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready8), .in_z(in_z),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_sum(out_sum8), .out_ovf(out_ovf8)
    );

    addsub_accum #(.N(N), .COUNT(COUNT), .ACC_W(6)) d6 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready6), .in_z(in_z),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_sum(out_sum6), .out_ovf(out_ovf6)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s8;
        bit o8;
        int s6;
        bit o6;
    } exp_t;

    exp_t exp_q[$];
    int   samples[$];
    bit   m_hold = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Wrap an integer into the signed range of a w-bit word
    function automatic int wrap(input int t, input int w);
        int m;
        int r;
        m = 1 << w;
        r = ((t % m) + m) % m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Running wrapped sum of the current frame; overflow when any true partial sum leaves range
    function automatic void frame_calc(input int w, output int s, output bit o);
        int r;
        int t;
        int lo;
        int hi;
        r  = 0;
        o  = 1'b0;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        foreach (samples[i]) begin
            t = r + samples[i];
            if (t < lo || t > hi) o = 1'b1;
            r = wrap(t, w);
        end
        s = r & ((1 << w) - 1);
    endfunction

    function automatic void model_reset();
        m_hold = 1'b0;
        samples.delete();
        exp_q.delete();
    endfunction

    // Apply one cycle of inputs, then advance the reference model across the edge
    task automatic step(input bit v, input logic [5:0] z, input bit ordy, input bit c);
        exp_t e;
        in_valid  = v;
        in_z      = z;
        out_ready = ordy;
        clr       = c;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (v) begin
            samples.push_back(int'($signed(z)));
            if (samples.size() == COUNT) begin
                frame_calc(8, e.s8, e.o8);
                frame_calc(6, e.s6, e.o6);
                exp_q.push_back(e);
                samples.delete();
                m_hold = 1'b1;
            end
        end
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic frame4(input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] c, input logic [5:0] d);
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string name, input int s8, input bit o8,
                              input int s6, input bit o6);
        chk({name, "_valid8"}, int'(out_valid8), 1);
        chk({name, "_sum8"}, int'(out_sum8), s8);
        chk({name, "_ovf8"}, int'(out_ovf8), int'(o8));
        chk({name, "_sum6"}, int'(out_sum6), s6);
        chk({name, "_ovf6"}, int'(out_ovf6), int'(o6));
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid8", int'(out_valid8), 0);
        chk("arst_sum8", int'(out_sum8), 0);
        chk("arst_ovf8", int'(out_ovf8), 0);
        chk("arst_valid6", int'(out_valid6), 0);
        chk("arst_sum6", int'(out_sum6), 0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // Monitor: per-cycle handshake checks and scoreboard pop on output handshake
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n) begin
            chk("in_ready8", int'(in_ready8), int'(!m_hold));
            chk("in_ready6", int'(in_ready6), int'(!m_hold));
            chk("out_valid8", int'(out_valid8), int'(m_hold));
            chk("out_valid6", int'(out_valid6), int'(m_hold));
            if (out_valid8) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("mon_sum8", int'(out_sum8), e.s8);
                    chk("mon_ovf8", int'(out_ovf8), int'(e.o8));
                    chk("mon_sum6", int'(out_sum6), e.s6);
                    chk("mon_ovf6", int'(out_ovf6), int'(e.o6));
                    if (out_ready && !clr) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_valid8", int'(out_valid8), 0);
        chk("rst_sum8", int'(out_sum8), 0);
        chk("rst_ovf8", int'(out_ovf8), 0);
        chk("rst_ready8", int'(in_ready8), 1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Basic frame: 4, 4, -2, 3 -> 9
        frame4(6'd4, 6'd4, 6'b111110, 6'd3);
        expect_out("basic", 9, 1'b0, 9, 1'b0);
        chk("basic_hold_ready", int'(in_ready8), 0);
        step(1'b0, 6'd0, 1'b1, 1'b0);
        chk("basic_after_hs_valid", int'(out_valid8), 0);
        chk("basic_after_hs_ready", int'(in_ready8), 1);

        // Backpressure: stalled output, input offered but refused
        frame4(6'd1, 6'd1, 6'd1, 6'd1);
        repeat (5) step(1'b1, 6'd1, 1'b0, 1'b0);
        expect_out("bp_stable", 4, 1'b0, 4, 1'b0);
        step(1'b1, 6'd1, 1'b1, 1'b0);
        chk("bp_drop_valid", int'(out_valid8), 0);
        frame4(6'd1, 6'd1, 6'd1, 6'd1);
        expect_out("bp_next", 4, 1'b0, 4, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0);

        // Overflow in the 6-bit instance, flag cleared per frame
        frame4(6'd20, 6'd20, 6'd0, 6'd0);
        expect_out("ovf", 40, 1'b0, 40, 1'b1);
        step(1'b0, 6'd0, 1'b1, 1'b0);
        frame4(6'd1, 6'd1, 6'd1, 6'd1);
        expect_out("ovf_next", 4, 1'b0, 4, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0);

        // Async reset mid-frame discards partial data
        step(1'b1, 6'd7, 1'b0, 1'b0);
        step(1'b1, 6'd7, 1'b0, 1'b0);
        async_reset();
        frame4(6'd4, 6'd4, 6'd4, 6'd4);
        expect_out("post_arst", 16, 1'b0, 16, 1'b0);

        // Clear in HOLD beats the output handshake
        step(1'b0, 6'd0, 1'b1, 1'b1);
        chk("clr_hold_valid", int'(out_valid8), 0);
        chk("clr_hold_sum", int'(out_sum8), 0);
        chk("clr_hold_ready", int'(in_ready8), 1);
        // Clear with an accept drops the sample
        step(1'b1, 6'd5, 1'b0, 1'b1);
        frame4(6'd1, 6'd1, 6'd1, 6'd1);
        expect_out("clr_drop", 4, 1'b0, 4, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0);

        // Gapped input of -1
        step(1'b1, 6'b111111, 1'b0, 1'b0);
        step(1'b0, 6'b111111, 1'b0, 1'b0);
        step(1'b0, 6'b111111, 1'b0, 1'b0);
        step(1'b1, 6'b111111, 1'b0, 1'b0);
        step(1'b0, 6'b111111, 1'b0, 1'b0);
        step(1'b1, 6'b111111, 1'b0, 1'b0);
        chk("gap_not_done", int'(out_valid8), 0);
        step(1'b1, 6'b111111, 1'b0, 1'b0);
        expect_out("gap", 252, 1'b0, 60, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), 6'($urandom()),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
        end

        // Drain any pending frame, bounded
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step(1'b0, 6'd0, 1'b1, 1'b0);
        end
        chk("drain_empty", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
